// File: rtl/dtt_xbar_pkg.sv
// Shared types and helpers for the crossbar output arbiters.
package dtt_xbar_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } xbar_arb_state_e;

  // Upper bound on inputs the round-robin search can handle.
  localparam int RR_MAX = 32;

  // Round-robin search: first set bit of req at or after ptr, wrapping at n.
  function automatic void rr_pick(
    input  logic [RR_MAX-1:0] req,
    input  int                n,
    input  int                ptr,
    output int                win,
    output logic              found
  );
    int idx;
    win   = 0;
    found = 1'b0;
    for (int k = 0; k < RR_MAX; k++) begin
      idx = ptr + k;
      if (idx >= n) idx = idx - n;
      if (k < n && !found && req[idx[4:0]]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  endfunction

endpackage

// File: rtl/dtt_crossbar_arbiter_if.sv
// Request / switch-control bundle between input ports, arbiter and switch.
interface dtt_crossbar_arbiter_if #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 4,
  parameter int IN_W  = $clog2(N_IN),
  parameter int OUT_W = $clog2(N_OUT)
);
  logic [N_IN-1:0]             req_valid;
  logic [N_IN-1:0][OUT_W-1:0]  req_dest;
  logic [N_IN-1:0]             req_last;
  logic [N_IN-1:0]             req_ready;
  logic [N_OUT-1:0]            out_ready;
  logic [N_OUT-1:0][IN_W-1:0]  xbar_sel;
  logic [N_OUT-1:0]            xbar_valid;
  logic [N_OUT-1:0]            busy;

  modport master (
    output req_valid, req_dest, req_last, out_ready,
    input  req_ready, xbar_sel, xbar_valid, busy
  );

  modport slave (
    input  req_valid, req_dest, req_last, out_ready,
    output req_ready, xbar_sel, xbar_valid, busy
  );
endinterface

// File: rtl/dtt_rr_out_arbiter.sv
// One output's arbiter: round-robin grant, packet lock, per-input ready.
module dtt_rr_out_arbiter #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 4,
  parameter int IN_W  = $clog2(N_IN),
  parameter int OUT_W = $clog2(N_OUT),
  parameter int O     = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_IN-1:0]            req_valid,
  input  logic [N_IN-1:0][OUT_W-1:0] req_dest,
  input  logic [N_IN-1:0]            req_last,
  input  logic                       out_ready,
  output logic [N_IN-1:0]            ready_vec,
  output logic                       xbar_valid,
  output logic [IN_W-1:0]            xbar_sel,
  output logic                       busy
);
  import dtt_xbar_pkg::*;

  xbar_arb_state_e   state;
  logic [IN_W-1:0]   gnt;
  logic [IN_W-1:0]   rr;
  logic [N_IN-1:0]   cand;
  logic [RR_MAX-1:0] cand_ext;
  int                pick_win;
  logic              pick_found;
  logic [IN_W-1:0]   nxt_rr;
  logic              fire;

  // Inputs currently asking for this output.
  always_comb begin
    cand     = '0;
    cand_ext = '0;
    for (int i = 0; i < N_IN; i++)
      cand[i] = req_valid[i] && (req_dest[i] == OUT_W'(O));
    cand_ext[N_IN-1:0] = cand;
  end

  // Round-robin winner starting at the pointer.
  always_comb begin
    pick_win   = 0;
    pick_found = 1'b0;
    rr_pick(cand_ext, N_IN, int'(rr), pick_win, pick_found);
  end

  assign nxt_rr = (pick_win == N_IN - 1) ? '0 : IN_W'(pick_win + 1);

  // A beat passes only while locked and the owner still targets us.
  assign fire = (state == ARB_LOCKED) && req_valid[gnt] &&
                (req_dest[gnt] == OUT_W'(O)) && out_ready;

  // Ready goes only to the owning input.
  always_comb begin
    ready_vec      = '0;
    ready_vec[gnt] = fire;
  end

  assign xbar_valid = fire;
  assign xbar_sel   = gnt;
  assign busy       = (state == ARB_LOCKED);

  // Grant on IDLE, release after the last beat; pointer moves only on grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARB_IDLE;
      gnt   <= '0;
      rr    <= '0;
    end else begin
      case (state)
        ARB_IDLE: if (pick_found) begin
          gnt   <= IN_W'(pick_win);
          rr    <= nxt_rr;
          state <= ARB_LOCKED;
        end
        ARB_LOCKED: if (fire && req_last[gnt]) state <= ARB_IDLE;
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/dtt_crossbar_arbiter.sv
// Crossbar scheduler: one round-robin arbiter per output, readies ORed per input.
module dtt_crossbar_arbiter #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 4,
  parameter int IN_W  = $clog2(N_IN),
  parameter int OUT_W = $clog2(N_OUT)
) (
  input logic                   clk,
  input logic                   rst,
  dtt_crossbar_arbiter_if.slave bus
);
  import dtt_xbar_pkg::*;

  logic [N_OUT-1:0][N_IN-1:0] rdy;
  logic [N_OUT-1:0][IN_W-1:0] sel;
  logic [N_OUT-1:0]           xv;
  logic [N_OUT-1:0]           bsy;
  logic [N_IN-1:0]            rdy_or;

  for (genvar o = 0; o < N_OUT; o++) begin : g_out
    dtt_rr_out_arbiter #(
      .N_IN(N_IN), .N_OUT(N_OUT), .IN_W(IN_W), .OUT_W(OUT_W), .O(o)
    ) u_arb (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (bus.req_valid),
      .req_dest   (bus.req_dest),
      .req_last   (bus.req_last),
      .out_ready  (bus.out_ready[o]),
      .ready_vec  (rdy[o]),
      .xbar_valid (xv[o]),
      .xbar_sel   (sel[o]),
      .busy       (bsy[o])
    );
  end

  // Each input has one destination, so at most one term is set per input.
  always_comb begin
    rdy_or = '0;
    for (int o = 0; o < N_OUT; o++) rdy_or = rdy_or | rdy[o];
  end

  assign bus.req_ready  = rdy_or;
  assign bus.xbar_sel   = sel;
  assign bus.xbar_valid = xv;
  assign bus.busy       = bsy;

endmodule

// File: doc/dtt_crossbar_arbiter.md
# dtt_crossbar_arbiter

Per-output round-robin scheduler that sits in front of `dtt_crossbar_switch`. It takes one request per input port, arbitrates among inputs contending for the same output, and locks the winning input onto that output for a whole multi-beat packet. It drives the switch's per-output select and valid lines and returns per-input ready for backpressure.

## Interface
- `N_IN`, 4, number of input ports (≥2)
- `N_OUT`, 4, number of output ports (≥2)
- `IN_W`, `$clog2(N_IN)`, select index width
- `OUT_W`, `$clog2(N_OUT)`, destination index width

- `clk`  in  1  clock; all state changes on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req_valid`  in  1 ×[N_IN]  input i has a beat for `req_dest[i]`
- `req_dest`  in  OUT_W ×[N_IN]  binary destination output index
- `req_last`  in  1 ×[N_IN]  current beat is the final beat of the packet
- `req_ready`  out  1 ×[N_IN]  beat on input i is accepted this cycle
- `out_ready`  in  1 ×[N_OUT]  downstream of output o can take a beat
- `xbar_sel`  out  IN_W ×[N_OUT]  input currently owning output o
- `xbar_valid`  out  1 ×[N_OUT]  beat transfers through output o this cycle
- `busy`  out  N_OUT  bit o set while output o is LOCKED

## Operation
- Each output o runs an independent 2-state FSM: IDLE and LOCKED. It also keeps a grant register `gnt[o]` (IN_W bits) and a round-robin pointer `rr[o]` (IN_W bits).
- Candidate set for output o: every input i with `req_valid[i]` and `req_dest[i]==o`.
- IDLE, with a non-empty candidate set:
  - Search i = rr[o], rr[o]+1, …, wrapping modulo N_IN. The first candidate found wins.
  - Registered updates: `gnt[o]`←winner, `rr[o]`←(winner+1) mod N_IN, state←LOCKED.
- IDLE, with an empty candidate set: hold all state.
- LOCKED, where g=`gnt[o]`:
  - fire = `req_valid[g] & (req_dest[g]==o) & out_ready[o]`.
  - `req_ready[g]` = fire and `xbar_valid[o]` = fire.
  - When fire and `req_last[g]` are both true: state←IDLE at the next edge. `rr[o]` is unchanged.
  - A beat without last, or no fire: stay LOCKED. Other inputs get no ready from o.
- `req_ready[i]` is the OR over all outputs; at most one term can be set, because each input has exactly one destination.
- `xbar_sel[o]` = `gnt[o]` in both states (it holds its last value while IDLE).
- `busy[o]` = (state==LOCKED).
- Changing `req_dest[i]` mid-packet is illegal. If it happens, the locked output stops firing and stays LOCKED until the original destination is restored.
- Reset (asynchronous, any time, including mid-packet): all FSMs go to IDLE, `gnt` and `rr` go to 0. Outputs during reset: `req_ready`=0, `xbar_valid`=0, `xbar_sel`=0, `busy`=0. A packet cut off by reset is abandoned, not resumed.

## Timing
- Grant latency: a request first visible in cycle t on an IDLE output gives LOCKED from t+1. The first `req_ready` can be seen in t+1.
- Single-beat packet with `out_ready`=1: ready and valid for one cycle (t+1); IDLE again at t+2.
- Re-arbitration bubble: exactly one IDLE cycle between a last beat and the next grant on the same output.
- `req_ready` and `xbar_valid` depend combinationally on `req_valid`, `req_dest` and `out_ready`. There is no combinational path from any input to `xbar_sel` or `busy`.
- Fairness: with all N_IN inputs continuously requesting output o, each is granted once every N_IN packets.

## Structure
- Package `dtt_xbar_pkg` holds:
  - the state typedef (`xbar_arb_state_e`: ARB_IDLE, ARB_LOCKED);
  - a `rr_pick` function (request vector plus pointer in, winner index and found flag out).
- Sub-module `dtt_rr_out_arbiter`: one output's FSM, pointer and grant register. The top instantiates it N_OUT times in a generate loop and ORs the per-output ready vectors.

## Test plan
- Reset: hold `rst`=1 with arbitrary requests → all outputs 0. Release, then assert `rst` while output 2 is LOCKED → `busy[2]`=0 immediately and `xbar_sel[2]`=0.
- Contention:
  - Setup: inputs 0 and 1 → dest 2, input 2 → dest 1, input 3 → dest 3, all single-beat, `out_ready`=all 1.
  - Expected, cycle 1: `xbar_sel[2]`=0, `xbar_sel[1]`=2, `xbar_sel[3]`=3, all firing.
  - Expected, cycle 3: input 1 fires on output 2.
- Packet lock: input 0 sends a 4-beat packet to output 1 while input 3 requests output 1 → input 3 gets no ready until the cycle after input 0's last beat plus one bubble.
- Backpressure: `out_ready[2]`=0 for 3 cycles mid-packet → `req_ready` stays 0, `busy[2]` stays 1, no beats are lost, and the packet completes once ready returns.
- Fairness: all 4 inputs stream single-beat packets to output 0 for 16 grants → grant sequence 0,1,2,3,0,1,2,3,… with each input granted exactly 4 times.
- Pointer wrap: `rr[0]`=3 and only inputs 0 and 3 request → input 3 wins, then `rr[0]`=0 and input 0 wins next.
